nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: nibble-serial adder (optionally subtractor) with valid/ready handshake.
//   ripple_carry_addr : 4-bit ripple-carry adder (a_i, b_i, c_i -> s_o, c_o).
//   nibble_serial_add_ctrl ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     in_valid/in_ready, A, B, Cin  operand handshake (Sub too when NIBBLE_SERIAL_SUB_EN is defined)
//     out_valid/out_ready, Sum, Cout, Ovf  result handshake
//   NIBBLE_SERIAL_SUB_EN: adds input Sub; Sub=1 computes A-B-!Cin by feeding ~B to the adder.

module ripple_carry_addr (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;
    assign c[0] = c_i;
    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
        assign c[g + 1] = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
    end
    assign c_o = c[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int N  = WIDTH / 4;
    localparam int KW = $clog2(N + 1);
    localparam logic [KW-1:0] LAST = KW'(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, b_eff_d;
    logic             a_msb_q, b_msb_q, carry_q, cout_q, ovf_q, out_valid_q;
    logic [KW-1:0]    k_q;
    logic [3:0]       nib_s;
    logic             nib_c;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign b_eff_d = Sub ? ~B : B;
`else
    assign b_eff_d = B;
`endif

    // Operands shift right one nibble per cycle so the adder always sees bits [3:0];
    // the sign bits are kept aside for the overflow decision.
    ripple_carry_addr u_add (
        .a_i(a_q[3:0]),
        .b_i(b_q[3:0]),
        .c_i(carry_q),
        .s_o(nib_s),
        .c_o(nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            k_q         <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= A;
                    b_q     <= b_eff_d;
                    a_msb_q <= A[WIDTH-1];
                    b_msb_q <= b_eff_d[WIDTH-1];
                    carry_q <= Cin;
                    k_q     <= '0;
                    state_q <= RUN;
                end
                RUN: if (k_q == LAST) begin
                    // All nibbles written; this extra cycle registers the flags.
                    cout_q      <= carry_q;
                    ovf_q       <= (a_msb_q == b_msb_q) && (sum_q[WIDTH-1] != a_msb_q);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    sum_q[4*k_q +: 4] <= nib_s;
                    carry_q           <= nib_c;
                    a_q               <= a_q >> 4;
                    b_q               <= b_q >> 4;
                    k_q               <= k_q + KW'(1);
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: scoreboard bench for nibble_serial_add_ctrl (WIDTH=16).
module tb_nibble_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Cin = 1'b0;
    logic        Sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          acc;
        int          st;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_acc = 0;
    int   xfer_edge = 0;
    int   dcnt = 0;
    bit   seen = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .Cin(Cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .Sub(Sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Sum(Sum),
        .Cout(Cout),
        .Ovf(Ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic; overflow judged by the signed range.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic sb, input int st);
        exp_t        e;
        logic [15:0] be;
        logic [16:0] full;
        int          sa, w;
        be   = sb ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, ci};
        sa   = int'($signed(a)) + int'($signed(be)) + (ci ? 1 : 0);
        e.s  = full[15:0];
        e.c  = full[16];
        e.v  = (sa > 32767) || (sa < -32768);
        e.st = st;
        @(negedge clk);
        A = a; B = b; Cin = ci; Sub = sb; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(w), 32'(0));
            in_valid = 1'b0;
            return;
        end
        e.acc    = cyc + 1;
        last_acc = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        Cin = 1'($urandom);
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            dcnt = 0;
            seen = 0;
        end else begin
            if (q.size() > 0 && cyc >= q[0].acc) chk("in_ready_busy", 32'(in_ready), 32'(0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'(0));
                    out_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(5));
                        seen = 1;
                    end
                    chk("sum", 32'(Sum), 32'(q[0].s));
                    chk("cout", 32'(Cout), 32'(q[0].c));
                    chk("ovf", 32'(Ovf), 32'(q[0].v));
                    out_ready = (dcnt >= q[0].st);
                    dcnt++;
                    if (out_ready) begin
                        void'(q.pop_front());
                        xfer_edge = cyc + 1;
                        seen = 0;
                        dcnt = 0;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        int rel, w;
        in_valid = 1'b1;
        out_ready = 1'b1;
        A = 16'hBEEF;
        B = 16'h1234;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_sum", 32'(Sum), 32'(0));
        chk("rst_cout", 32'(Cout), 32'(0));
        chk("rst_ovf", 32'(Ovf), 32'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rel = cyc;
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        chk("first_edge_accept", 32'(last_acc), 32'(rel + 1));
        op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        op(16'h8000, 16'h8000, 1'b0, 1'b0, 2);
        op(16'h1357, 16'h2468, 1'b1, 1'b0, 3);
        op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);
        chk("accept_after_xfer", 32'(last_acc), 32'(xfer_edge + 1));
`ifdef NIBBLE_SERIAL_SUB_EN
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        op(16'h8000, 16'h0001, 1'b1, 1'b1, 1);
`endif
        op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_out_valid", 32'(out_valid), 32'(0));
        chk("abort_sum", 32'(Sum), 32'(0));
        chk("abort_cout", 32'(Cout), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
`ifdef NIBBLE_SERIAL_SUB_EN
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
`else
            op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 3)));
`endif
        end
        w = 0;
        while (q.size() > 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("drain", 32'(q.size()), 32'(0));
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
